// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: drives load/load_val/start/pause/abort, observes busy/tick/remain/done.
// slave : the timer side of the same signals.
interface countdown_timer_if #(
    parameter int unsigned CNT_W = 11
);
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
    logic             busy;
    logic             tick;
    logic [CNT_W-1:0] remain;
    logic             done;

    modport master (
        output load, load_val, start, pause, abort,
        input  busy, tick, remain, done
    );

    modport slave (
        input  load, load_val, start, pause, abort,
        output busy, tick, remain, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting timer. A prescaler of N = CLK_PER_MS*TICK_MS cycles
// produces a tick while running; each tick decrements remain, and reaching
// zero pulses done for one cycle.
// Ports:
//   sys_clk  - clock, rising edge
//   sys_rst  - asynchronous active-high reset
//   bus      - countdown_timer_if.slave: load/load_val/start/pause/abort in,
//              busy/tick (combinational)/remain/done out
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to reload remain from
// reload_val on expiry and keep running; otherwise the timer is one-shot.
// N must be at least 2.
module countdown_timer #(
    parameter int unsigned CLK_PER_MS = 50_000,
    parameter int unsigned TICK_MS    = 1000,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    countdown_timer_if.slave bus
);
    localparam int unsigned N  = CLK_PER_MS * TICK_MS;
    localparam int unsigned PW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             tick_c;
    logic             last_c;
    logic             reload_ok_c;

    assign tick_c = (state_q == S_RUN) && (presc_q == PW'(N - 1));
    assign last_c = (remain_q == CNT_W'(1));

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign reload_ok_c = (reload_q != '0);
`else
    assign reload_ok_c = 1'b0;
`endif

    assign bus.busy   = busy_q;
    assign bus.tick   = tick_c;
    assign bus.remain = remain_q;
    assign bus.done   = done_q;

    // State register; busy is registered from the next state so it lines up with done
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Next-state logic; abort overrides everything, load shadows start in IDLE
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.load && bus.start && (remain_q != '0)) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.pause) begin
                        state_d = S_PAUSED;
                    end else if (tick_c && last_c && !reload_ok_c) begin
                        state_d = S_IDLE;
                    end
                end
                S_PAUSED: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values; pause freezes the prescaler, so a paused cycle never counts
    always_comb begin
        presc_d  = presc_q;
        remain_d = remain_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.abort) begin
            presc_d  = '0;
            remain_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        remain_d = bus.load_val;
                        reload_d = bus.load_val;
                    end else if (bus.start) begin
                        if (remain_q != '0) begin
                            presc_d = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.pause) begin
                        presc_d = tick_c ? '0 : presc_q + PW'(1);
                        if (tick_c) begin
                            if (last_c) begin
                                done_d   = 1'b1;
                                remain_d = reload_ok_c ? reload_q : '0;
                            end else begin
                                remain_d = remain_q - CNT_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q  <= '0;
            remain_q <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            remain_q <= remain_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer for game timing (round timers, move deadlines, respawn delays). A millisecond prescaler derived from `sys_clk` generates a tick every `TICK_MS` milliseconds while running, and a remaining-count register decrements on each tick. The block pulses `done` when the count reaches zero. It complements the free-running up-counter tick source: software loads a duration, starts it, and waits for expiry instead of polling an elapsed count.

## Interface
- `CLK_PER_MS`, 50_000: `sys_clk` cycles per millisecond (20 ns clock).
- `TICK_MS`, 1000: milliseconds per decrement tick.
- `CNT_W`, 11: width of the loaded and remaining count.
- Derived, not overridable: `N` = `CLK_PER_MS*TICK_MS`. Prescaler width is `$clog2(N)`. `N` ≥ 2 is required.

- `sys_clk`, in, 1: single clock domain; all logic on the rising edge.
- `sys_rst`, in, 1: reset, asynchronous and active-high.
- `load`, in, 1: single-cycle strobe; captures `load_val` into `remain` and `reload_val`.
- `load_val`, in, `CNT_W`: duration, in ticks.
- `start`, in, 1: begin or resume counting.
- `pause`, in, 1: freeze counting; the prescaler keeps its value.
- `abort`, in, 1: stop immediately and clear `remain`.
- `busy`, out, 1: high in RUN or PAUSED.
- `tick`, out, 1: combinational; high when state = RUN and prescaler = `N`-1.
- `remain`, out, `CNT_W`: ticks remaining.
- `done`, out, 1: registered single-cycle expiry pulse.

## Operation
- FSM states are IDLE, RUN and PAUSED.
- Input priority, highest first: `abort`, then `load`, then `start`, then `pause`.
- `abort`, from any state:
  - State goes to IDLE; `remain` and the prescaler go to 0.
  - `done` is not pulsed, and `reload_val` is kept.
- `load`: accepted only in IDLE; ignored in RUN and PAUSED. `remain` and `reload_val` take `load_val`.
- `start` in IDLE:
  - If `remain` ≠ 0: clear the prescaler and go to RUN.
  - If `remain` = 0: stay in IDLE and pulse `done` on the next cycle.
- `start` in PAUSED: go to RUN. The prescaler resumes from its held value and is not cleared.
- `pause` in RUN: go to PAUSED. The prescaler and `remain` hold.
- `start` or `pause` in any other state is ignored.
- Prescaler in RUN: increments each cycle and wraps `N`-1 → 0 (wrap coincides with `tick`).
- On `tick`:
  - `remain` decrements by 1.
  - If `remain` = 1 at the tick: `remain` becomes 0, `done` is 1 on the next cycle, and the state goes to IDLE (see Configuration).
- `remain` never underflows. A decrement from 0 cannot occur because RUN is never entered with `remain` = 0.
- `load`, `start` and `abort` asserted in the same cycle: `abort` wins; `load` and `start` are discarded.

## Timing
- Reset values: state IDLE, prescaler 0, `remain` 0, `reload_val` 0, `busy` 0, `done` 0, `tick` 0.
- `start` sampled at edge E0 (from IDLE):
  - `busy` rises after E0.
  - First `tick` is in the cycle before edge E0+`N`.
  - `remain` decrements at E0+`N`.
- Total run time for a load of V with no pause: V·`N` cycles from the `start` edge until `done` is high.
- `done` is high for exactly one cycle. It coincides with `remain` = 0 and `busy` = 0 (same edge).
- `load` takes effect at the next edge, so `remain` is valid one cycle after the strobe.
- Pause/resume: the total number of RUN cycles needed to expire is unchanged by any number of pause intervals.
- Reset mid-run: all outputs go to their reset values asynchronously. No `done` pulse is produced.

## Configuration
- Macro: `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - On expiry, `remain` takes `reload_val` and the state stays in RUN; the prescaler continues wrapping.
  - `done` still pulses once per period, and `busy` stays 1.
  - Period is `reload_val`·`N` cycles.
  - If `reload_val` = 0: go to IDLE as in non-reload mode.
- Not defined: expiry always returns to IDLE (one-shot). The `reload_val` register is still present but is used only by the defined build.

## Test plan
All scenarios use `CLK_PER_MS`=4, `TICK_MS`=1, so `N`=4.
- Reset then `load_val`=3, `load`, `start` → `tick` at 4, 8 and 12 cycles after start. `remain` steps 3→2→1→0. `done` is a single pulse exactly 12 cycles after the start edge, with `busy`=0.
- Load 5, start, `pause` after 6 cycles for 10 cycles, then `start` → `done` at 20 RUN cycles (30 cycles total). `remain` holds 4 throughout the pause.
- Load 4, start, `abort` after 7 cycles → `busy`=0 and `remain`=0 next cycle. No `done` pulse.
- `start` with `remain`=0 → `done` pulses next cycle and `busy` stays 0. Also: `load` of 9 during RUN → ignored, and `remain` continues unaffected.
- Assert `sys_rst` mid-run with `remain`=2 → all outputs 0 immediately. A subsequent load of 1 plus `start` gives `done` 4 cycles later.
- With `COUNTDOWN_AUTO_RELOAD_EN`: load 2, start → `done` pulses at cycles 8, 16 and 24. `busy` stays 1 and `remain` cycles 2,1,2,1.
